arbitro_decodificador: RTL and testbench

Round-robin arbiter and sequencer that shares a single 3-to-8 one-hot decoder stage between several requesters. Each requester presents a decode address and a request. The block grants one requester at a time, latches its address and drives the decoded one-hot output for a fixed number of cycles. It then signals completion and inserts a one-cycle break-before-make gap. It sits between the requesting control logic and the decoded select/enable lines.

---
 rtl/arbitro_decodificador.sv | 127 ++++++++++++
 tb/tb_arbitro_decodificador.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_decodificador.sv
// Round-robin arbiter feeding a shared ADDR_W-to-2^ADDR_W one-hot decoder.
// Each grant drives S for HOLD cycles, pulses done on the last one, then idles one GAP cycle.
module arbitro_decodificador #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 3,
  parameter int HOLD   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ADDR_W-1:0]   addr,
  output logic [(1<<ADDR_W)-1:0]    S,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          done,
  output logic                      busy
);

  localparam int OUT_W = 1 << ADDR_W;
  localparam int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW    = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [PW:0] N_EXT = (PW+1)'(N_REQ);

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [OUT_W-1:0]   s_q, s_d;

  logic [ADDR_W-1:0]  addr_arr [N_REQ];
  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [PW-1:0]      off;
  logic [PW:0]        sum, sum_wrap;
  logic [PW-1:0]      win_idx, ptr_next;
  logic               win_valid;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_addr
    assign addr_arr[gi] = addr[gi*ADDR_W +: ADDR_W];
  end

  // Rotating the doubled request vector by ptr turns round-robin into a fixed-priority search.
  assign req_dbl = {req, req};
  assign req_rot = req_dbl[{1'b0, ptr_q} +: N_REQ];

  always_comb begin
    off       = '0;
    win_valid = |req;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) off = PW'(k);
    end
  end

  assign sum      = {1'b0, ptr_q} + {1'b0, off};
  assign sum_wrap = sum - N_EXT;
  assign win_idx  = (sum >= N_EXT) ? sum_wrap[PW-1:0] : sum[PW-1:0];
  assign ptr_next = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + PW'(1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_valid) state_d = ACTIVE;
      ACTIVE:  if (cnt_q == '0) state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    gnt_d = gnt_q;
    s_d   = s_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          ptr_d = ptr_next;
          cnt_d = CW'(HOLD - 1);
          gnt_d = N_REQ'(1) << win_idx;
          s_d   = OUT_W'(1) << addr_arr[win_idx];
        end
      end
      ACTIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          gnt_d = '0;
          s_d   = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
      gnt_q <= '0;
      s_q   <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      gnt_q <= gnt_d;
      s_q   <= s_d;
    end
  end

  // Output logic: done marks the last ACTIVE cycle of the current grant.
  always_comb begin
    done = '0;
    busy = (state_q != IDLE);
    if (state_q == ACTIVE && cnt_q == '0) done = gnt_q;
  end

  assign S   = s_q;
  assign gnt = gnt_q;

endmodule

// File: tb/tb_arbitro_decodificador.sv
// Bench for arbitro_decodificador: directed tables and sequences plus random traffic
// compared against a schedule-based model; a second HOLD=1 instance covers the short build.
module tb_arbitro_decodificador;

  localparam int N  = 4;
  localparam int AW = 3;
  localparam int H  = 4;
  localparam int OW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*AW-1:0] addr = '0;
  logic [OW-1:0]   S;
  logic [N-1:0]    gnt, done;
  logic            busy;

  logic [N-1:0]    req_b = '0;
  logic [N*AW-1:0] addr_b = '0;
  logic [OW-1:0]   S_b;
  logic [N-1:0]    gnt_b, done_b;
  logic            busy_b;

  always #5 clk = ~clk;

  arbitro_decodificador #(.N_REQ(N), .ADDR_W(AW), .HOLD(H)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .addr(addr),
    .S(S), .gnt(gnt), .done(done), .busy(busy));

  arbitro_decodificador #(.N_REQ(N), .ADDR_W(AW), .HOLD(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .addr(addr_b),
    .S(S_b), .gnt(gnt_b), .done(done_b), .busy(busy_b));

  typedef struct packed {
    logic [OW-1:0] s;
    logic [N-1:0]  g;
    logic [N-1:0]  d;
    logic          b;
  } out_t;

  typedef struct packed {
    logic [N-1:0]    r;
    logic [N*AW-1:0] a;
    out_t            e;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Model: once a grant is decided, its whole output timeline is queued up front.
  out_t exp_q[$];
  int   m_ptr = 0;

  function automatic out_t cur();
    out_t o;
    o = '{s: S, g: gnt, d: done, b: busy};
    return o;
  endfunction

  function automatic out_t cur_b();
    out_t o;
    o = '{s: S_b, g: gnt_b, d: done_b, b: busy_b};
    return o;
  endfunction

  task automatic chk(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got S=%b gnt=%b done=%b busy=%b, want S=%b gnt=%b done=%b busy=%b",
               name, act.s, act.g, act.d, act.b, exp.s, exp.g, exp.d, exp.b);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic model_arb(input logic [N-1:0] r, input logic [N*AW-1:0] a);
    int w;
    int av;
    w = -1;
    if (exp_q.size() == 0 && r != '0) begin
      for (int k = 0; k < N; k++)
        if (w < 0 && r[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      av = int'(a[w*AW +: AW]);
      for (int c = 0; c < H; c++)
        exp_q.push_back('{s: OW'(1) << av, g: N'(1) << w,
                          d: (c == H - 1) ? (N'(1) << w) : N'(0), b: 1'b1});
      exp_q.push_back('{s: '0, g: '0, d: '0, b: 1'b1});
      exp_q.push_back('{s: '0, g: '0, d: '0, b: 1'b0});
      m_ptr = (w + 1) % N;
      $display("grant requester=%0d addr=%0d t=%0t", w, av, $time);
    end
  endtask

  task automatic cycle();
    out_t e;
    model_arb(req, addr);
    @(posedge clk);
    #1;
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    chk("model", cur(), e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  vec_t tbl [7];

  initial begin
    // Single request from requester 0 at address 5, dropped right after being sampled.
    tbl[0] = '{r: 4'b0001, a: 12'h005, e: '{s: 8'h20, g: 4'b0001, d: 4'b0000, b: 1'b1}};
    tbl[1] = '{r: 4'b0000, a: 12'h005, e: '{s: 8'h20, g: 4'b0001, d: 4'b0000, b: 1'b1}};
    tbl[2] = '{r: 4'b0000, a: 12'h005, e: '{s: 8'h20, g: 4'b0001, d: 4'b0000, b: 1'b1}};
    tbl[3] = '{r: 4'b0000, a: 12'h005, e: '{s: 8'h20, g: 4'b0001, d: 4'b0001, b: 1'b1}};
    tbl[4] = '{r: 4'b0000, a: 12'h005, e: '{s: 8'h00, g: 4'b0000, d: 4'b0000, b: 1'b1}};
    tbl[5] = '{r: 4'b0000, a: 12'h005, e: '{s: 8'h00, g: 4'b0000, d: 4'b0000, b: 1'b0}};
    tbl[6] = '{r: 4'b0000, a: 12'h005, e: '{s: 8'h00, g: 4'b0000, d: 4'b0000, b: 1'b0}};

    // Reset state; all requesters already asserting for the round-robin sequence.
    req  = 4'b1111;
    addr = {3'd5, 3'd4, 3'd3, 3'd2};
    #3;
    chk("reset_outputs", cur(), '0);
    chk("reset_outputs_b", cur_b(), '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < H + 2; c++) begin
        cycle();
        if (c == 0) begin
          chk_int("rr_gnt", int'(gnt), 1 << (g % N));
          chk_int("rr_s", int'(S), 1 << ((g % N) + 2));
          if (g == 4) req = '0;
        end
      end
    end

    foreach (tbl[i]) begin
      req  = tbl[i].r;
      addr = tbl[i].a;
      cycle();
      chk("table", cur(), tbl[i].e);
    end

    // Wrap and skip: grant 2 leaves ptr at 3, so 0101 gives 0 then 2.
    req = 4'b0100;
    cycle();
    chk_int("skip_g2_first", int'(gnt), 4);
    req = 4'b0101;
    run(5);
    cycle();
    chk_int("wrap_g0", int'(gnt), 1);
    run(5);
    cycle();
    chk_int("skip_g2", int'(gnt), 4);
    req = 4'b1001;
    run(5);
    cycle();
    chk_int("ptr_at_3", int'(gnt), 8);
    req = '0;
    run(5);

    // Mid-grant changes to req and addr must not disturb requester 1's grant.
    req  = 4'b0010;
    addr = 12'h018;
    cycle();
    chk("mid_a1", cur(), '{s: 8'h08, g: 4'b0010, d: 4'b0000, b: 1'b1});
    cycle();
    req  = '0;
    addr = 12'h038;
    cycle();
    chk("mid_a3", cur(), '{s: 8'h08, g: 4'b0010, d: 4'b0000, b: 1'b1});
    cycle();
    chk("mid_a4", cur(), '{s: 8'h08, g: 4'b0010, d: 4'b0010, b: 1'b1});
    run(2);

    // Asynchronous reset in the middle of ACTIVE.
    req  = 4'b0001;
    addr = 12'h007;
    run(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", cur(), '0);
    req = '0;
    exp_q.delete();
    m_ptr = 0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_held", cur(), '0);
    rst_n = 1'b1;
    run(3);

    for (int i = 0; i < 400; i++) begin
      req  = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      addr = 12'($urandom);
      cycle();
    end
    req = '0;
    run(H + 2);

    // HOLD=1 build: one ACTIVE cycle carrying done, period of three cycles.
    req_b  = 4'b0010;
    addr_b = 12'h000;
    for (int p = 0; p < 2; p++) begin
      cycle();
      chk("h1_active", cur_b(), '{s: 8'h01, g: 4'b0010, d: 4'b0010, b: 1'b1});
      cycle();
      chk("h1_gap", cur_b(), '{s: 8'h00, g: 4'b0000, d: 4'b0000, b: 1'b1});
      cycle();
      chk("h1_idle", cur_b(), '0);
    end
    req_b = '0;
    run(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
